conv_sched: RTL and testbench

Pipelined issue scheduler for the 2D-convolution datapath. It replaces the stop-and-wait sequencing between the input memories, the MAC pipeline and the output FIFO. Addresses and MAC controls for consecutive output elements are issued back-to-back, with no per-element drain. A credit counter mirrors free FIFO space so a result never arrives at a full FIFO. The block sits between the input memory (address/config side), the MAC pipe (control side) and the output FIFO (valid/pop side).

---
 rtl/conv_pkg.sv | 38 +++
 rtl/conv_addr_gen.sv | 84 ++++++++
 rtl/conv_sched.sv | 163 ++++++++++++++++
 tb/tb_conv_sched.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared types, sizes and helpers for the conv_sched issue scheduler.
//   R, C        input feature-map rows / cols
//   MAXK        largest supported kernel size
//   MAC_LAT     cycles from a mac_input_valid cycle to its product in mac_out
//   FIFO_DEPTH  output FIFO entries (initial credit count)
//   state_t     scheduler FSM states
//   kvalid()    kernel-size legality check
package conv_pkg;

  localparam int R          = 8;
  localparam int C          = 8;
  localparam int MAXK       = 5;
  localparam int MAC_LAT    = 4;
  localparam int FIFO_DEPTH = 7;

  localparam int X_ADDR_BITS = $clog2(R * C);
  localparam int W_ADDR_BITS = $clog2(MAXK * MAXK);
  localparam int K_BITS      = $clog2(MAXK + 1);
  localparam int CNT_BITS    = $clog2((R > C) ? R : C);
  localparam int CR_BITS     = $clog2(FIFO_DEPTH + 1);
  localparam int IF_BITS     = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CHECK      = 3'd1,
    ISSUE_INIT = 3'd2,
    ISSUE_FEED = 3'd3,
    STALL      = 3'd4,
    DRAIN      = 3'd5,
    DONE       = 3'd6
  } state_t;

  // A kernel fits when it is non-empty and no larger than the map or MAXK.
  function automatic logic kvalid(input int k, input int r, input int c, input int maxk);
    return (k >= 1) && (k <= r) && (k <= maxk) && (k <= c);
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: output-element (row/col) and kernel-tap (i/j) counters plus
// the memory address arithmetic for conv_sched.
//   clk, reset      clock, synchronous active-high reset
//   i_start         clear all counters (new computation)
//   i_init          clear tap counters (start of an element)
//   i_feed          advance one tap, j fastest, then the element position
//   i_k             latched kernel size
//   o_x_addr        (row+i)*C + (col+j)
//   o_w_addr        i*K + j
//   o_last_feed     current feed cycle is the element's final tap
//   o_last_element  current element is the final one of the output map
module conv_addr_gen
  import conv_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic                   i_init,
  input  logic                   i_feed,
  input  logic [K_BITS-1:0]      i_k,
  output logic [X_ADDR_BITS-1:0] o_x_addr,
  output logic [W_ADDR_BITS-1:0] o_w_addr,
  output logic                   o_last_feed,
  output logic                   o_last_element
);

  logic [CNT_BITS-1:0] r_row;
  logic [CNT_BITS-1:0] r_col;
  logic [CNT_BITS-1:0] r_i;
  logic [CNT_BITS-1:0] r_j;

  logic w_last_j;
  logic w_last_i;
  logic w_last_col;
  logic w_last_row;

  // Output map is (R-K+1) x (C-K+1), so the last row/col index is R-K / C-K.
  always_comb begin
    w_last_j   = (int'(r_j) == int'(i_k) - 1);
    w_last_i   = (int'(r_i) == int'(i_k) - 1);
    w_last_col = (int'(r_col) == C - int'(i_k));
    w_last_row = (int'(r_row) == R - int'(i_k));
  end

  assign o_last_feed    = i_feed && w_last_i && w_last_j;
  assign o_last_element = w_last_row && w_last_col;

  assign o_x_addr = X_ADDR_BITS'((int'(r_row) + int'(r_i)) * C + int'(r_col) + int'(r_j));
  assign o_w_addr = W_ADDR_BITS'(int'(r_i) * int'(i_k) + int'(r_j));

  always_ff @(posedge clk) begin
    if (reset || i_start) begin
      r_row <= '0;
      r_col <= '0;
      r_i   <= '0;
      r_j   <= '0;
    end else if (i_init) begin
      r_i <= '0;
      r_j <= '0;
    end else if (i_feed) begin
      if (!w_last_j) begin
        r_j <= r_j + CNT_BITS'(1);
      end else begin
        r_j <= '0;
        if (!w_last_i) begin
          r_i <= r_i + CNT_BITS'(1);
        end else begin
          r_i <= '0;
          // Wrap to the origin after the final element so idle addresses read 0.
          if (o_last_element) begin
            r_row <= '0;
            r_col <= '0;
          end else if (w_last_col) begin
            r_col <= '0;
            r_row <= r_row + CNT_BITS'(1);
          end else begin
            r_col <= r_col + CNT_BITS'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/conv_sched.sv
// conv_sched: pipelined issue scheduler for the 2D-convolution datapath.
// Issues X/W addresses and MAC controls for consecutive output elements
// back-to-back, and uses a credit counter mirroring free output FIFO space.
//   clk, reset        clock, synchronous active-high reset
//   inputs_loaded     level: X/W/K/B ready, starts a computation from IDLE
//   K                 kernel size, stable while inputs_loaded
//   X_read_addr       input memory address
//   W_read_addr       weight memory address
//   mac_init_acc      load accumulator with bias
//   mac_input_valid   accumulate current X_data*W_data
//   fifo_in_valid     mac_out holds a finished element (1-cycle pulse)
//   fifo_in_ready     FIFO can accept
//   fifo_pop          downstream consumed one FIFO entry
//   compute_finished  1-cycle pulse, all results written
//   cfg_err           sticky: bad K or result dropped at a non-ready FIFO
//   o_dbg_state       FSM state
//   o_dbg_credits     free FIFO entries not yet reserved
//
// FIFO handshake: fifo_in_valid is a push pulse with no backpressure; a
// push while fifo_in_ready=0 loses the result and sets cfg_err. Credits are
// reserved at issue time and returned on fifo_pop, so a well-behaved FIFO is
// never full when a result arrives.
module conv_sched
  import conv_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inputs_loaded,
  input  logic [K_BITS-1:0]      K,
  output logic [X_ADDR_BITS-1:0] X_read_addr,
  output logic [W_ADDR_BITS-1:0] W_read_addr,
  output logic                   mac_init_acc,
  output logic                   mac_input_valid,
  output logic                   fifo_in_valid,
  input  logic                   fifo_in_ready,
  input  logic                   fifo_pop,
  output logic                   compute_finished,
  output logic                   cfg_err,
  output state_t                 o_dbg_state,
  output logic [CR_BITS-1:0]     o_dbg_credits
);

  state_t              r_state;
  state_t              w_next;
  logic [K_BITS-1:0]   r_k;
  logic [CR_BITS-1:0]  r_credits;
  logic [IF_BITS-1:0]  r_inflight;
  logic [MAC_LAT:0]    r_pipe;
  logic                r_mac_init;
  logic                r_mac_valid;
  logic                r_err;

  logic w_k_ok;
  logic w_credit_ok;
  logic w_reserve;
  logic w_last_feed;
  logic w_last_element;

  assign w_k_ok      = kvalid(int'(K), R, C, MAXK);
  assign w_credit_ok = (r_credits != '0);
  assign w_reserve   = (r_state == ISSUE_INIT);

  conv_addr_gen u_addr_gen (
    .clk            (clk),
    .reset          (reset),
    .i_start        (r_state == CHECK),
    .i_init         (r_state == ISSUE_INIT),
    .i_feed         (r_state == ISSUE_FEED),
    .i_k            (r_k),
    .o_x_addr       (X_read_addr),
    .o_w_addr       (W_read_addr),
    .o_last_feed    (w_last_feed),
    .o_last_element (w_last_element)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:       if (inputs_loaded) w_next = CHECK;
      CHECK: begin
        if (!w_k_ok)          w_next = DONE;
        else if (w_credit_ok) w_next = ISSUE_INIT;
        else                  w_next = STALL;
      end
      ISSUE_INIT: w_next = ISSUE_FEED;
      ISSUE_FEED: begin
        if (w_last_feed) begin
          if (w_last_element)   w_next = DRAIN;
          else if (w_credit_ok) w_next = ISSUE_INIT;
          else                  w_next = STALL;
        end
      end
      STALL:      if (w_credit_ok) w_next = ISSUE_INIT;
      DRAIN:      if (r_inflight == '0) w_next = DONE;
      DONE:       w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                              r_k <= '0;
    else if (r_state == CHECK && w_k_ok)    r_k <= K;
  end

  // Reserve and pop in the same cycle cancel; pops saturate at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_credits <= CR_BITS'(FIFO_DEPTH);
    end else if (w_reserve && !fifo_pop) begin
      r_credits <= r_credits - CR_BITS'(1);
    end else if (!w_reserve && fifo_pop && r_credits != CR_BITS'(FIFO_DEPTH)) begin
      r_credits <= r_credits + CR_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= '0;
    end else if (w_reserve && !fifo_in_valid) begin
      r_inflight <= r_inflight + IF_BITS'(1);
    end else if (!w_reserve && fifo_in_valid) begin
      r_inflight <= r_inflight - IF_BITS'(1);
    end
  end

  // Memory reads take one cycle, so the MAC controls are the state delayed
  // by one cycle. r_pipe[0] tags an element's last mac_input_valid cycle;
  // MAC_LAT stages later the finished element is in mac_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mac_init  <= 1'b0;
      r_mac_valid <= 1'b0;
      r_pipe      <= '0;
    end else begin
      r_mac_init  <= (r_state == ISSUE_INIT);
      r_mac_valid <= (r_state == ISSUE_FEED);
      r_pipe      <= {r_pipe[MAC_LAT-1:0], w_last_feed};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      if (r_state == CHECK)             r_err <= !w_k_ok;
      if (fifo_in_valid && !fifo_in_ready) r_err <= 1'b1;
    end
  end

  assign mac_init_acc     = r_mac_init;
  assign mac_input_valid  = r_mac_valid;
  assign fifo_in_valid    = r_pipe[MAC_LAT];
  assign compute_finished = (r_state == DONE);
  assign cfg_err          = r_err;
  assign o_dbg_state      = r_state;
  assign o_dbg_credits    = r_credits;

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: directed bench for conv_sched. Cycle numbers are counted
// from the cycle in which inputs_loaded is seen in IDLE (cycle 0).
module tb_conv_sched;
  import conv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                   inputs_loaded;
  logic [K_BITS-1:0]      K;
  logic [X_ADDR_BITS-1:0] X_read_addr;
  logic [W_ADDR_BITS-1:0] W_read_addr;
  logic                   mac_init_acc;
  logic                   mac_input_valid;
  logic                   fifo_in_valid;
  logic                   fifo_in_ready;
  logic                   fifo_pop;
  logic                   compute_finished;
  logic                   cfg_err;
  state_t                 dbg_state;
  logic [CR_BITS-1:0]     dbg_credits;

  conv_sched dut (
    .clk              (clk),
    .reset            (reset),
    .inputs_loaded    (inputs_loaded),
    .K                (K),
    .X_read_addr      (X_read_addr),
    .W_read_addr      (W_read_addr),
    .mac_init_acc     (mac_init_acc),
    .mac_input_valid  (mac_input_valid),
    .fifo_in_valid    (fifo_in_valid),
    .fifo_in_ready    (fifo_in_ready),
    .fifo_pop         (fifo_pop),
    .compute_finished (compute_finished),
    .cfg_err          (cfg_err),
    .o_dbg_state      (dbg_state),
    .o_dbg_credits    (dbg_credits)
  );

  // ---------------- scoreboard state ----------------
  int n_assert = 0;
  int n_fail   = 0;
  int cyc;
  int n_fiv, first_fiv, last_fiv, n_cf, cf_cyc, n_mac;
  logic auto_pop;
  logic   fiv_log [0:1023];
  logic   ini_log [0:1023];
  logic   val_log [0:1023];
  state_t st_log  [0:1023];
  logic [X_ADDR_BITS-1:0] act_x[$];
  logic [W_ADDR_BITS-1:0] act_w[$];
  logic [X_ADDR_BITS-1:0] exp_x[$];
  logic [W_ADDR_BITS-1:0] exp_w[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    n_fiv = 0; first_fiv = -1; last_fiv = -1;
    n_cf = 0; cf_cyc = -1; n_mac = 0;
    act_x.delete(); act_w.delete();
    for (int n = 0; n < 1024; n++) begin
      fiv_log[n] = 1'b0; ini_log[n] = 1'b0; val_log[n] = 1'b0; st_log[n] = IDLE;
    end
  endtask

  // Called mid-cycle (negedge): record outputs, drive the auto-pop response.
  task automatic log_cycle();
    if (cyc >= 0 && cyc < 1024) begin
      fiv_log[cyc] = fifo_in_valid;
      ini_log[cyc] = mac_init_acc;
      val_log[cyc] = mac_input_valid;
      st_log[cyc]  = dbg_state;
    end
    if (fifo_in_valid) begin
      n_fiv++;
      if (first_fiv < 0) first_fiv = cyc;
      last_fiv = cyc;
    end
    if (compute_finished) begin
      n_cf++;
      if (cf_cyc < 0) cf_cyc = cyc;
    end
    if (mac_init_acc || mac_input_valid) n_mac++;
    if (dbg_state == ISSUE_FEED) begin
      act_x.push_back(X_read_addr);
      act_w.push_back(W_read_addr);
    end
    if (auto_pop) fifo_pop = fifo_in_valid;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    log_cycle();
  endtask

  task automatic go_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic run_until_done(input int budget);
    for (int n = 0; n < budget && cf_cyc < 0; n++) step();
  endtask

  // Must be called at a negedge with the DUT in IDLE.
  task automatic start(input logic [K_BITS-1:0] k);
    clear_stats();
    K = k;
    cyc = 0;
    inputs_loaded = 1'b1;
    log_cycle();
    step();
    inputs_loaded = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    inputs_loaded = 1'b0;
    fifo_pop = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"},     32'(X_read_addr), 0);
    chk({tag, "_w"},     32'(W_read_addr), 0);
    chk({tag, "_init"},  32'(mac_init_acc), 0);
    chk({tag, "_valid"}, 32'(mac_input_valid), 0);
    chk({tag, "_fiv"},   32'(fifo_in_valid), 0);
    chk({tag, "_cf"},    32'(compute_finished), 0);
    chk({tag, "_err"},   32'(cfg_err), 0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    chk({tag, "_cred"},  32'(dbg_credits), FIFO_DEPTH);
  endtask

  // ---------------- directed sequence ----------------
  int n_off;

  initial begin
    reset = 1'b1; inputs_loaded = 1'b0; K = 3;
    fifo_in_ready = 1'b1; fifo_pop = 1'b0; auto_pop = 1'b0; cyc = 0;
    clear_stats();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    // Pop with a full credit count must saturate.
    fifo_pop = 1'b1;
    step();
    fifo_pop = 1'b0;
    chk("pop_at_full_credits", 32'(dbg_credits), FIFO_DEPTH);

    // ---- K=3, pops follow every result ----
    auto_pop = 1'b1;
    start(3);
    chk("a_check_state", 32'(dbg_state), 32'(CHECK));
    run_until_done(600);
    step(); step();
    chk("a_issue_init_c2", 32'(st_log[2]), 32'(ISSUE_INIT));
    chk("a_init_acc_c2", 32'(ini_log[2]), 0);
    chk("a_init_acc_c3", 32'(ini_log[3]), 1);
    for (int c = 3; c <= 13; c++)
      chk($sformatf("a_mac_valid_c%0d", c), 32'(val_log[c]), (c >= 4 && c <= 12) ? 1 : 0);
    n_off = 0;
    for (int c = 0; c < 1024; c++)
      if (fiv_log[c] && (c < 16 || ((c - 16) % 10) != 0)) n_off++;
    chk("a_fiv_off_grid", 32'(n_off), 0);
    chk("a_fiv_count", 32'(n_fiv), 36);
    chk("a_first_fiv", 32'(first_fiv), 16);
    chk("a_last_fiv", 32'(last_fiv), 366);
    chk("a_cf_cycle", 32'(cf_cyc), 368);
    chk("a_cf_pulses", 32'(n_cf), 1);
    chk("a_back_idle", 32'(dbg_state), 32'(IDLE));
    chk("a_cfg_err", 32'(cfg_err), 0);
    exp_x.delete(); exp_w.delete();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            exp_x.push_back(X_ADDR_BITS'((r + i) * 8 + c + j));
            exp_w.push_back(W_ADDR_BITS'(i * 3 + j));
          end
    chk("a_feed_count", 32'(act_x.size()), 324);
    for (int n = 0; n < exp_x.size() && n < act_x.size(); n++) begin
      chk($sformatf("a_x_addr_%0d", n), 32'(act_x[n]), 32'(exp_x[n]));
      chk($sformatf("a_w_addr_%0d", n), 32'(act_w[n]), 32'(exp_w[n]));
    end

    // ---- K=3, no pops: credits run out after 7 elements ----
    auto_pop = 1'b0;
    fifo_pop = 1'b0;
    start(3);
    go_to(120);
    chk("b_fiv_count", 32'(n_fiv), 7);
    chk("b_feed_c71", 32'(st_log[71]), 32'(ISSUE_FEED));
    chk("b_stall_c72", 32'(st_log[72]), 32'(STALL));
    chk("b_stall_c120", 32'(dbg_state), 32'(STALL));
    chk("b_credits_zero", 32'(dbg_credits), 0);
    fifo_pop = 1'b1;
    step();
    fifo_pop = 1'b0;
    chk("b_credit_back", 32'(dbg_credits), 1);
    chk("b_still_stall", 32'(dbg_state), 32'(STALL));
    step();
    chk("b_issue_init", 32'(dbg_state), 32'(ISSUE_INIT));
    // Reserve and pop in the same cycle leave the credit count unchanged.
    fifo_pop = 1'b1;
    step();
    fifo_pop = 1'b0;
    chk("b_reserve_pop_same", 32'(dbg_credits), 1);
    chk("b_feed_8th", 32'(dbg_state), 32'(ISSUE_FEED));
    chk("b_init_acc_8th", 32'(mac_init_acc), 1);
    do_reset();

    // ---- K=1: 64 results, period 2 ----
    auto_pop = 1'b1;
    start(1);
    run_until_done(600);
    step();
    n_off = 0;
    for (int c = 0; c < 1024; c++)
      if (fiv_log[c] && (c < 8 || ((c - 8) % 2) != 0)) n_off++;
    chk("c_fiv_off_grid", 32'(n_off), 0);
    chk("c_fiv_count", 32'(n_fiv), 64);
    chk("c_first_fiv", 32'(first_fiv), 8);
    chk("c_last_fiv", 32'(last_fiv), 134);
    chk("c_cf_cycle", 32'(cf_cyc), 136);
    chk("c_feed_count", 32'(act_x.size()), 64);
    for (int n = 0; n < 64 && n < act_x.size(); n++) begin
      chk($sformatf("c_x_addr_%0d", n), 32'(act_x[n]), n);
      chk($sformatf("c_w_addr_%0d", n), 32'(act_w[n]), 0);
    end

    // ---- K=0 and K=6: rejected ----
    start(0);
    chk("d_check", 32'(dbg_state), 32'(CHECK));
    step();
    chk("d_cf", 32'(compute_finished), 1);
    chk("d_err", 32'(cfg_err), 1);
    step(); step();
    chk("d_idle", 32'(dbg_state), 32'(IDLE));
    chk("d_err_sticky", 32'(cfg_err), 1);
    chk("d_no_mac", 32'(n_mac), 0);
    chk("d_cf_pulses", 32'(n_cf), 1);

    start(6);
    step();
    chk("e_cf", 32'(compute_finished), 1);
    chk("e_err", 32'(cfg_err), 1);
    step(); step();
    chk("e_no_mac", 32'(n_mac), 0);

    // ---- valid start clears cfg_err; reset mid element 5 ----
    start(3);
    step();
    chk("f_err_cleared", 32'(cfg_err), 0);
    go_to(45);
    chk("f_feed_el5", 32'(dbg_state), 32'(ISSUE_FEED));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all_zero("f_abort");
    step(); step();
    chk("f_no_cf", 32'(n_cf), 0);

    // ---- fresh restart from origin; FIFO not ready at a result ----
    fifo_in_ready = 1'b0;
    start(3);
    step();
    chk("g_init", 32'(dbg_state), 32'(ISSUE_INIT));
    chk("g_credits", 32'(dbg_credits), FIFO_DEPTH);
    step();
    chk("g_x_c3", 32'(X_read_addr), 0);
    chk("g_w_c3", 32'(W_read_addr), 0);
    step();
    chk("g_x_c4", 32'(X_read_addr), 1);
    chk("g_w_c4", 32'(W_read_addr), 1);
    go_to(6);
    chk("g_x_c6", 32'(X_read_addr), 8);
    chk("g_w_c6", 32'(W_read_addr), 3);
    go_to(16);
    chk("g_fiv_c16", 32'(fifo_in_valid), 1);
    chk("g_err_c16", 32'(cfg_err), 0);
    step();
    chk("g_err_c17", 32'(cfg_err), 1);
    fifo_in_ready = 1'b1;
    do_reset();

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
